// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg
//   Shared definitions for the PWM capture block: default widths and timeout,
//   FSM state encoding, and a saturating increment used by every counter.
//   FILT_LEN_DEF is only present when PWM_CAPTURE_GLITCH_FILT_EN is defined.
package pwm_cap_pkg;

  localparam int DUTY_W_DEF  = 10;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 4096;
`ifdef PWM_CAPTURE_GLITCH_FILT_EN
  localparam int FILT_LEN_DEF = 3;
`endif

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t ST_IDLE = 2'd0;
  localparam cap_state_t ST_HIGH = 2'd1;
  localparam cap_state_t ST_LOW  = 2'd2;

  // Counters are widened to 32 bits by the caller and truncated back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    if (val >= max_val) return max_val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_cap_sync.sv
// pwm_cap_sync
//   Brings the asynchronous PWM line into the clk domain and produces
//   single-cycle rise/fall pulses. With PWM_CAPTURE_GLITCH_FILT_EN defined,
//   a new level is only accepted after FILT_LEN consecutive equal samples.
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   pwm_in  in   asynchronous PWM line
//   level_o out  synchronized (and optionally filtered) line level
//   rise_o  out  1-cycle pulse on a rising edge of level_o
//   fall_o  out  1-cycle pulse on a falling edge of level_o
module pwm_cap_sync
  import pwm_cap_pkg::*;
`ifdef PWM_CAPTURE_GLITCH_FILT_EN
#(
  parameter int FILT_LEN = FILT_LEN_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [3:0] arm_q;
  logic       armed;
  logic       lvl;

  // Edges are suppressed until the whole chain holds real samples, so a line
  // that is already high when reset releases does not look like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      arm_q   <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      arm_q   <= {arm_q[2:0], 1'b1};
    end
  end

  assign armed = arm_q[3];

`ifdef PWM_CAPTURE_GLITCH_FILT_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic            filt_q;
  logic [FC_W-1:0] fcnt_q;

  // fcnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (!armed) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FC_W'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign level_o = lvl;
  assign rise_o  = armed &  lvl & ~prev_q;
  assign fall_o  = armed & ~lvl &  prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures high time and period of an incoming PWM line and recovers the
//   duty code of the 10-bit PWM generator (which drives high for code+1
//   cycles). Stuck lines are reported after TIMEOUT cycles without an edge.
//   Optional glitch filter: define PWM_CAPTURE_GLITCH_FILT_EN.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   pwm_in   in   asynchronous PWM line
//   en       in   capture enable; low forces IDLE and clears counters
//   duty     out  recovered duty code
//   period   out  last measured period in clk cycles
//   valid    out  1-cycle strobe when duty/period are updated
//   stuck_hi out  line held high for TIMEOUT cycles
//   stuck_lo out  line held low for TIMEOUT cycles
//
// state | meaning
// IDLE  | waiting for a rise to start a measurement
// HIGH  | line high, high and period counters running
// LOW   | line low, period counter running, high count frozen
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
`ifdef PWM_CAPTURE_GLITCH_FILT_EN
  ,
  parameter int FILT_LEN = FILT_LEN_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              stuck_hi,
  output logic              stuck_lo
);

  // Idle counter saturates above TIMEOUT so the timeout fires only once.
  localparam int          IDLE_W   = $clog2(TIMEOUT + 2);
  localparam logic [31:0] CNT_MAX  = 32'({CNT_W{1'b1}});
  localparam logic [31:0] IDLE_MAX = 32'({IDLE_W{1'b1}});
  localparam logic [31:0] DUTY_MAX = 32'({DUTY_W{1'b1}});

  logic line_lvl;
  logic rise;
  logic fall;
  logic any_edge;

  pwm_cap_sync
`ifdef PWM_CAPTURE_GLITCH_FILT_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_in  (pwm_in),
      .level_o (line_lvl),
      .rise_o  (rise),
      .fall_o  (fall)
    );

  assign any_edge = rise | fall;

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              stuck_hi_q, stuck_hi_d;
  logic              stuck_lo_q, stuck_lo_d;

  logic [CNT_W-1:0]  high_inc;
  logic [CNT_W-1:0]  per_inc;
  logic [IDLE_W-1:0] idle_inc;
  logic [DUTY_W-1:0] duty_meas;
  logic              timeout;

  always_comb begin
    high_inc = CNT_W'(sat_inc(32'(high_cnt_q), CNT_MAX));
    per_inc  = CNT_W'(sat_inc(32'(per_cnt_q), CNT_MAX));
    idle_inc = IDLE_W'(sat_inc(32'(idle_cnt_q), IDLE_MAX));
    timeout  = (idle_cnt_q == IDLE_W'(TIMEOUT));
    // Generator holds the line high for code+1 cycles.
    if (high_cnt_q == '0) begin
      duty_meas = '0;
    end else if ((32'(high_cnt_q) - 32'd1) > DUTY_MAX) begin
      duty_meas = '1;
    end else begin
      duty_meas = DUTY_W'(32'(high_cnt_q) - 32'd1);
    end
  end

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    per_cnt_d  = per_cnt_q;
    idle_cnt_d = idle_cnt_q;
    duty_d     = duty_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;

    if (!en) begin
      state_d    = ST_IDLE;
      high_cnt_d = '0;
      per_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = any_edge ? '0 : idle_inc;
      if (any_edge) begin
        stuck_hi_d = 1'b0;
        stuck_lo_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d    = ST_HIGH;
            high_cnt_d = CNT_W'(1);
            per_cnt_d  = CNT_W'(1);
          end else if (timeout && !any_edge && !line_lvl) begin
            duty_d     = '0;
            stuck_lo_d = 1'b1;
            valid_d    = 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_d   = ST_LOW;
            per_cnt_d = per_inc;
          end else if (timeout && !any_edge) begin
            duty_d     = '1;
            stuck_hi_d = 1'b1;
            valid_d    = 1'b1;
            state_d    = ST_IDLE;
            high_cnt_d = '0;
            per_cnt_d  = '0;
          end else begin
            high_cnt_d = high_inc;
            per_cnt_d  = per_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            duty_d     = duty_meas;
            period_d   = per_cnt_q;
            valid_d    = 1'b1;
            state_d    = ST_HIGH;
            high_cnt_d = CNT_W'(1);
            per_cnt_d  = CNT_W'(1);
          end else if (timeout && !any_edge) begin
            duty_d     = '0;
            stuck_lo_d = 1'b1;
            valid_d    = 1'b1;
            state_d    = ST_IDLE;
            high_cnt_d = '0;
            per_cnt_d  = '0;
          end else begin
            per_cnt_d = per_inc;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          high_cnt_d = '0;
          per_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      high_cnt_q <= '0;
      per_cnt_q  <= '0;
      idle_cnt_q <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      per_cnt_q  <= per_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign duty     = duty_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign stuck_hi = stuck_hi_q;
  assign stuck_lo = stuck_lo_q;

endmodule
